// File: rtl/oconnt_counter_pkg.sv
// ---------------------------------------------------------------------------
// oconnt_counter_pkg
// Purpose : shared constants for the oconnt_counter Tiny Tapeout tile.
//           Counter width, prescaler width and the bit positions of the
//           control fields inside ui_in.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package oconnt_counter_pkg;

    localparam int WIDTH   = 8;
    localparam int PS_BITS = 7;

    // Control field positions inside ui_in
    localparam int HOLD_BIT = 0;
    localparam int DOWN_BIT = 1;
    localparam int LOAD_BIT = 2;
    localparam int CLR_BIT  = 3;
    localparam int PS_LSB   = 4;
    localparam int PS_MSB   = 6;

endpackage

// File: rtl/oconnt_counter_core.sv
// ---------------------------------------------------------------------------
// oconnt_counter_core
// Purpose : count register with priority clear > load > hold > step.
//           State changes only on enabled rising edges; reset is synchronous
//           and active-low and overrides everything.
// Ports   :
//   clk     in   clock, rising edge
//   rst_n   in   synchronous active-low reset
//   en      in   state-change enable
//   clr     in   clear count to zero
//   ld      in   load ld_val
//   ld_val  in   WIDTH-bit parallel load value
//   hold    in   freeze count
//   down    in   step direction (1 = decrement)
//   tick    in   step permission for this cycle
//   o_count out  WIDTH-bit count register
// ---------------------------------------------------------------------------
module oconnt_counter_core
    import oconnt_counter_pkg::*;
#(
    parameter int CNT_W = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_val,
    input  logic             hold,
    input  logic             down,
    input  logic             tick,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (en) begin
            if (clr) begin
                r_count <= '0;
            end else if (ld) begin
                r_count <= ld_val;
            end else if (hold) begin
                r_count <= r_count;
            end else if (tick) begin
                // Natural modulo-2^CNT_W wrap in both directions
                r_count <= down ? (r_count - 1'b1) : (r_count + 1'b1);
            end
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/oconnt_counter.sv
// ---------------------------------------------------------------------------
// oconnt_counter
// Purpose : Tiny Tapeout tile top. 8-bit up/down counter with clear,
//           parallel load and hold; count drives uo_out directly.
// Config  : define COUNTER_PRESCALE_EN to add a free-running prescaler
//           selected by ui_in[6:4] (tick when the low n prescaler bits are
//           all ones). Undefined: a step happens every cycle.
// Ports   :
//   clk      in   clock
//   rst_n    in   synchronous active-low reset
//   ena      in   tile enable; no state change when low
//   ui_in    in   [0] hold [1] down [2] load [3] clear [6:4] prescale [7] unused
//   uio_in   in   parallel load value
//   uo_out   out  current count
//   uio_out  out  tied 0
//   uio_oe   out  tied 0 (all uio pins are inputs)
// ---------------------------------------------------------------------------
module oconnt_counter
    import oconnt_counter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic w_hold;
    logic w_down;
    logic w_load;
    logic w_clr;
    logic w_tick;

    assign w_hold = ui_in[HOLD_BIT];
    assign w_down = ui_in[DOWN_BIT];
    assign w_load = ui_in[LOAD_BIT];
    assign w_clr  = ui_in[CLR_BIT];

`ifdef COUNTER_PRESCALE_EN
    logic [PS_BITS-1:0]       r_ps;
    logic [PS_BITS-1:0]       w_ps_mask;
    logic [PS_MSB-PS_LSB:0]   w_ps_n;

    assign w_ps_n = ui_in[PS_MSB:PS_LSB];

    // Mask of the low n prescaler bits; n=0 gives an empty mask -> tick every cycle
    always_comb begin
        w_ps_mask = '0;
        for (int i = 0; i < PS_BITS; i++) begin
            if (i < int'(w_ps_n)) begin
                w_ps_mask[i] = 1'b1;
            end
        end
    end

    assign w_tick = ((r_ps & w_ps_mask) == w_ps_mask);

    // Free-running; clear and load restart the phase so the first step
    // after a load lands exactly 2^n cycles later
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ps <= '0;
        end else if (ena) begin
            if (w_clr || w_load) begin
                r_ps <= '0;
            end else begin
                r_ps <= r_ps + 1'b1;
            end
        end
    end

    logic w_unused;
    assign w_unused = &{1'b0, ui_in[7]};
`else
    assign w_tick = 1'b1;

    logic               w_unused;
    logic [PS_BITS-1:0] w_unused_ps;
    assign w_unused_ps = '0;
    assign w_unused    = &{1'b0, ui_in[7:4], w_unused_ps};
`endif

    oconnt_counter_core #(
        .CNT_W (WIDTH)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (ena),
        .clr     (w_clr),
        .ld      (w_load),
        .ld_val  (uio_in),
        .hold    (w_hold),
        .down    (w_down),
        .tick    (w_tick),
        .o_count (uo_out)
    );

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_oconnt_counter.sv
// ---------------------------------------------------------------------------
// tb_oconnt_counter
// Purpose : directed-vector bench for oconnt_counter. Each applied vector
//           queues the count expected after its clock edge; a monitor on the
//           falling edge pops and compares, and also checks the uio tie-offs.
// ---------------------------------------------------------------------------
module tb_oconnt_counter;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    typedef struct {
        logic [7:0] exp;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec;
    int   n_bad;

    oconnt_counter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare once per cycle, away from the active edge
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (uo_out !== e.exp) begin
                n_bad++;
                $display("FAIL %s: uo_out=%h expected %h at %0t", e.tag, uo_out, e.exp, $time);
            end
            n_vec++;
            if ((uio_out !== 8'h00) || (uio_oe !== 8'h00)) begin
                n_bad++;
                $display("FAIL tieoff: uio_out=%h uio_oe=%h expected 00/00 at %0t",
                         uio_out, uio_oe, $time);
            end
        end
    end

    // Apply the current inputs across one rising edge, expecting value e after it
    task automatic step(input logic [7:0] e, input string tag);
        exp_t x;
        x.exp = e;
        x.tag = tag;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec  = 0;
        n_bad  = 0;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        // 1. Reset, then free count up
        step(8'h00, "reset");
        rst_n = 1'b1;
        for (int i = 1; i <= 20; i++) step(8'(i), "freecount");

        // 2. Wrap up through FF, then down through 00
        ui_in = 8'h04; uio_in = 8'hFE;
        step(8'hFE, "load_fe");
        ui_in = 8'h00;
        step(8'hFF, "wrap_up_ff");
        step(8'h00, "wrap_up_00");
        step(8'h01, "wrap_up_01");
        ui_in = 8'h02;
        step(8'h00, "down_00");
        step(8'hFF, "wrap_down_ff");
        step(8'hFE, "wrap_down_fe");

        // 3. Priority
        ui_in = 8'h0F; uio_in = 8'h77;
        step(8'h00, "prio_clr_wins");
        ui_in = 8'h05; uio_in = 8'h5A;
        step(8'h5A, "prio_load_over_hold");

        // 4. Hold and ena
        ui_in = 8'h01;
        for (int i = 0; i < 5; i++) step(8'h5A, "hold");
        ena = 1'b0; ui_in = 8'h08;
        step(8'h5A, "ena0_clear_ignored");
        ui_in = 8'h04; uio_in = 8'h11;
        step(8'h5A, "ena0_load_ignored");
        ui_in = 8'h00;
        step(8'h5A, "ena0_no_count");
        ena = 1'b1;
        step(8'h5B, "ena1_resume");
        ui_in = 8'h80;
        step(8'h5C, "bit7_ignored");

        // 5. Mid-run reset and direction change
        ui_in = 8'h04; uio_in = 8'h30;
        step(8'h30, "load_30");
        ui_in = 8'h00;
        for (int i = 1; i <= 7; i++) step(8'(8'h30 + i), "count_to_37");
        rst_n = 1'b0; ui_in = 8'h04; uio_in = 8'hAA;
        step(8'h00, "midrun_reset");
        rst_n = 1'b1; ui_in = 8'h00;
        step(8'h01, "resume_1");
        step(8'h02, "resume_2");
        ui_in = 8'h02;
        step(8'h01, "dir_down");
        ui_in = 8'h00;
        step(8'h02, "dir_up");

`ifdef COUNTER_PRESCALE_EN
        // 6. Prescale n=2: one step every 4 cycles, phase restarted by load
        ui_in = 8'h24; uio_in = 8'h10;
        step(8'h10, "ps_load");
        ui_in = 8'h20;
        step(8'h10, "ps_wait1");
        step(8'h10, "ps_wait2");
        step(8'h10, "ps_wait3");
        step(8'h11, "ps_tick1");
        step(8'h11, "ps_wait4");
        step(8'h11, "ps_wait5");
        step(8'h11, "ps_wait6");
        step(8'h12, "ps_tick2");
`else
        // Without the prescaler ui_in[6:4] has no effect
        ui_in = 8'h20;
        step(8'h03, "ps_ignored1");
        step(8'h04, "ps_ignored2");
`endif

        // Drain the scoreboard with a bounded wait
        repeat (3) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Absolute time bound
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1, "watchdog");
    end

endmodule
